mcu_target_router: RTL and testbench

- Sits between the MCU SPI byte interface and the MCU-facing targets: sysctrl, hid, osd and sdc.
- The first byte of every MCU frame selects the target. The router forwards the rest of the frame to that target as a normal start/strobe byte stream.
- It multiplexes the selected target's data_out back to the MCU.
- It aggregates per-target interrupt requests into pending latches. These are acknowledged through the sysctrl interrupt command (CMD 5) via the int_ack path.

---
 rtl/mcu_pkg.sv | 19 +
 rtl/mcu_target_router_irq_latch.sv | 38 +++
 rtl/mcu_target_router.sv | 134 +++++++++++++
 tb/tb_mcu_target_router.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU target router: target ids, FSM encoding
// and the default inactivity timeout.
package mcu_pkg;

    localparam int TGT_SYS = 0;
    localparam int TGT_HID = 1;
    localparam int TGT_OSD = 2;
    localparam int TGT_SDC = 3;

    localparam logic [15:0] DEFAULT_TIMEOUT = 16'd50000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

endpackage

// File: rtl/mcu_target_router_irq_latch.sv
// One interrupt source: rising-edge detect, pending latch with ack, and
// mask gating of the pending bit toward the combined MCU interrupt.
module irq_latch
    import mcu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic ack,
    input  logic mask,
    output logic pending,
    output logic masked
);

    logic src_prev_reg;
    logic pending_reg;
    logic rise;

    assign rise = src & ~src_prev_reg;

    // A new edge takes priority over an ack in the same clock so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev_reg <= 1'b0;
            pending_reg  <= 1'b0;
        end else begin
            src_prev_reg <= src;
            if (rise)
                pending_reg <= 1'b1;
            else if (ack)
                pending_reg <= 1'b0;
        end
    end

    assign pending = pending_reg;
    assign masked  = pending_reg & mask;

endmodule

// File: rtl/mcu_target_router.sv
// Routes MCU SPI frames to the target selected by the first byte, returns
// that target's data byte, and aggregates target interrupt requests.
module mcu_target_router
    import mcu_pkg::*;
#(
    parameter int          NUM_TGT = 4,
    parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mcu_strobe,
    input  logic                 mcu_start,
    input  logic [7:0]           mcu_din,
    output logic [7:0]           mcu_dout,
    output logic [NUM_TGT-1:0]   tgt_strobe,
    output logic                 tgt_start,
    output logic [7:0]           tgt_din,
    input  logic [8*NUM_TGT-1:0] tgt_dout,
    input  logic [NUM_TGT-1:0]   irq_src,
    input  logic [NUM_TGT-1:0]   irq_ack,
    input  logic [NUM_TGT-1:0]   irq_mask,
    output logic [NUM_TGT-1:0]   irq_pending,
    output logic                 int_out_n,
    output logic                 frame_err
);

    localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    state_t             state_reg, state_next;
    logic [TGT_W-1:0]   tgt_reg, tgt_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [NUM_TGT-1:0] strobe_reg, strobe_next;
    logic               start_reg, start_next;
    logic [7:0]         din_reg, din_next;
    logic [7:0]         dout_reg, dout_next;
    logic               err_reg, err_next;
    logic               int_n_reg;
    logic [NUM_TGT-1:0] masked;
    logic [7:0]         dout_arr [NUM_TGT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
            assign dout_arr[gi] = tgt_dout[8*gi +: 8];

            irq_latch u_irq (
                .clk     (clk),
                .reset   (reset),
                .src     (irq_src[gi]),
                .ack     (irq_ack[gi]),
                .mask    (irq_mask[gi]),
                .pending (irq_pending[gi]),
                .masked  (masked[gi])
            );
        end
    endgenerate

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            tgt_reg    <= '0;
            cnt_reg    <= '0;
            strobe_reg <= '0;
            start_reg  <= 1'b0;
            din_reg    <= 8'h00;
            dout_reg   <= 8'h00;
            err_reg    <= 1'b0;
            int_n_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            tgt_reg    <= tgt_next;
            cnt_reg    <= cnt_next;
            strobe_reg <= strobe_next;
            start_reg  <= start_next;
            din_reg    <= din_next;
            dout_reg   <= dout_next;
            err_reg    <= err_next;
            int_n_reg  <= ~|masked;
        end
    end

    // Frame decoding, forwarding, return mux and inactivity timeout.
    always_comb begin
        state_next  = state_reg;
        tgt_next    = tgt_reg;
        cnt_next    = cnt_reg;
        strobe_next = '0;
        start_next  = 1'b0;
        din_next    = din_reg;
        err_next    = 1'b0;
        dout_next   = ((state_reg == ST_CMD) || (state_reg == ST_DATA)) ?
                      dout_arr[tgt_reg] : 8'h00;

        if (mcu_strobe && mcu_start) begin
            // A start byte always restarts the frame, whatever state we are in.
            cnt_next = '0;
            if (32'(mcu_din) < NUM_TGT) begin
                tgt_next   = mcu_din[TGT_W-1:0];
                state_next = ST_CMD;
            end else begin
                state_next = ST_DROP;
                err_next   = 1'b1;
            end
        end else begin
            case (state_reg)
                ST_CMD, ST_DATA: begin
                    if (mcu_strobe) begin
                        strobe_next = NUM_TGT'(1) << tgt_reg;
                        start_next  = (state_reg == ST_CMD);
                        din_next    = mcu_din;
                        state_next  = ST_DATA;
                        cnt_next    = '0;
                    end else if (cnt_reg == TIMEOUT - 16'd1) begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                default: cnt_next = '0;
            endcase
        end
    end

    assign mcu_dout   = dout_reg;
    assign tgt_strobe = strobe_reg;
    assign tgt_start  = start_reg;
    assign tgt_din    = din_reg;
    assign int_out_n  = int_n_reg;
    assign frame_err  = err_reg;

endmodule

// File: tb/tb_mcu_target_router.sv
// Directed bench for mcu_target_router with a frame-level reference model
// checked every clock, plus literal expectations at key points.
module tb_mcu_target_router;
    import mcu_pkg::*;

    localparam int          NT = 4;
    localparam logic [15:0] TO = 16'd20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            mcu_strobe = 1'b0;
    logic            mcu_start = 1'b0;
    logic [7:0]      mcu_din = 8'h00;
    logic [7:0]      mcu_dout;
    logic [NT-1:0]   tgt_strobe;
    logic            tgt_start;
    logic [7:0]      tgt_din;
    logic [8*NT-1:0] tgt_dout = {8'h33, 8'h22, 8'h5C, 8'h11};
    logic [NT-1:0]   irq_src = '0;
    logic [NT-1:0]   irq_ack = '0;
    logic [NT-1:0]   irq_mask = 4'hF;
    logic [NT-1:0]   irq_pending;
    logic            int_out_n;
    logic            frame_err;

    int checks = 0;
    int errors = 0;

    mcu_target_router #(.NUM_TGT(NT), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .mcu_strobe(mcu_strobe), .mcu_start(mcu_start), .mcu_din(mcu_din),
        .mcu_dout(mcu_dout),
        .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_din(tgt_din),
        .tgt_dout(tgt_dout),
        .irq_src(irq_src), .irq_ack(irq_ack), .irq_mask(irq_mask),
        .irq_pending(irq_pending), .int_out_n(int_out_n), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the router.
    bit          m_in_frame, m_drop, m_cmd_done;
    int          m_tgt, m_idle;
    bit [NT-1:0] m_prev, m_pend;
    logic [NT-1:0] e_strobe;
    logic        e_start, e_err, e_intn;
    logic [7:0]  e_din, e_dout;

    always @(posedge clk) begin
        if (reset) begin
            m_in_frame = 0; m_drop = 0; m_cmd_done = 0; m_tgt = 0; m_idle = 0;
            m_prev = '0; m_pend = '0;
            e_strobe = '0; e_start = 0; e_err = 0; e_intn = 1; e_din = 8'h00; e_dout = 8'h00;
        end else begin
            bit active;
            active   = m_in_frame && !m_drop;
            e_dout   = active ? tgt_dout[8*m_tgt +: 8] : 8'h00;
            e_strobe = '0; e_start = 0; e_err = 0;
            if (mcu_strobe && mcu_start) begin
                m_in_frame = 1; m_idle = 0; m_cmd_done = 0;
                if (int'(mcu_din) < NT) begin
                    m_drop = 0; m_tgt = int'(mcu_din);
                end else begin
                    m_drop = 1; e_err = 1;
                end
            end else if (active) begin
                if (mcu_strobe) begin
                    e_strobe[m_tgt] = 1'b1;
                    e_start = !m_cmd_done;
                    e_din = mcu_din;
                    m_cmd_done = 1; m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == int'(TO)) begin
                        m_in_frame = 0; m_idle = 0; e_err = 1;
                    end
                end
            end
            e_intn = ~|(m_pend & irq_mask);
            for (int i = 0; i < NT; i++) begin
                if (irq_src[i] && !m_prev[i]) m_pend[i] = 1;
                else if (irq_ack[i]) m_pend[i] = 0;
            end
            m_prev = irq_src;
        end
        #1;
        check("model tgt_strobe", 32'(tgt_strobe), 32'(e_strobe));
        check("model tgt_start", 32'(tgt_start), 32'(e_start));
        check("model tgt_din", 32'(tgt_din), 32'(e_din));
        check("model mcu_dout", 32'(mcu_dout), 32'(e_dout));
        check("model frame_err", 32'(frame_err), 32'(e_err));
        check("model irq_pending", 32'(irq_pending), 32'(m_pend));
        check("model int_out_n", 32'(int_out_n), 32'(e_intn));
    end

    task automatic send(input logic st, input logic [7:0] d);
        @(negedge clk);
        mcu_strobe = 1'b1; mcu_start = st; mcu_din = d;
        @(negedge clk);
        mcu_strobe = 1'b0; mcu_start = 1'b0;
        $display("byte start=%0b din=%h -> strobe=%b start=%b din=%h dout=%h err=%b",
                 st, d, tgt_strobe, tgt_start, tgt_din, mcu_dout, frame_err);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        tick(3);
        check("reset mcu_dout", 32'(mcu_dout), 32'h00);
        check("reset tgt_strobe", 32'(tgt_strobe), 32'h0);
        check("reset irq_pending", 32'(irq_pending), 32'h0);
        check("reset int_out_n", 32'(int_out_n), 32'h1);
        reset = 1'b0;
        tick(2);

        // Frame to hid
        send(1'b1, 8'(TGT_HID));
        check("hid sel no strobe", 32'(tgt_strobe), 32'h0);
        send(1'b0, 8'h05);
        check("hid cmd strobe", 32'(tgt_strobe), 32'b0010);
        check("hid cmd start", 32'(tgt_start), 32'h1);
        check("hid cmd din", 32'(tgt_din), 32'h05);
        check("hid return", 32'(mcu_dout), 32'h5C);
        send(1'b0, 8'hAA);
        check("hid d0 strobe", 32'(tgt_strobe), 32'b0010);
        check("hid d0 start", 32'(tgt_start), 32'h0);
        check("hid d0 din", 32'(tgt_din), 32'hAA);
        send(1'b0, 8'hBB);
        check("hid d1 din", 32'(tgt_din), 32'hBB);
        tick(1);
        check("strobe is pulse", 32'(tgt_strobe), 32'h0);
        check("din holds", 32'(tgt_din), 32'hBB);

        // Bad target id
        send(1'b1, 8'h07);
        check("bad id err", 32'(frame_err), 32'h1);
        send(1'b0, 8'h11);
        check("drop no strobe", 32'(tgt_strobe), 32'h0);
        check("drop err pulse", 32'(frame_err), 32'h0);
        check("drop dout", 32'(mcu_dout), 32'h00);

        // Restart mid-DATA toward osd
        send(1'b1, 8'(TGT_SYS));
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        send(1'b1, 8'(TGT_OSD));
        check("restart no strobe", 32'(tgt_strobe), 32'h0);
        send(1'b0, 8'h09);
        check("restart strobe", 32'(tgt_strobe), 32'b0100);
        check("restart start", 32'(tgt_start), 32'h1);

        // Timeout
        send(1'b1, 8'(TGT_SYS));
        send(1'b0, 8'h03);
        n = 0;
        while (!frame_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout clocks", 32'(n), 32'(TO));
        check("timeout err", 32'(frame_err), 32'h1);
        send(1'b0, 8'h44);
        check("after timeout no strobe", 32'(tgt_strobe), 32'h0);

        // Interrupt timing
        @(negedge clk); irq_src[3] = 1'b1;
        @(negedge clk);
        check("irq3 pending", 32'(irq_pending), 32'b1000);
        check("irq3 int lag", 32'(int_out_n), 32'h1);
        @(negedge clk);
        check("irq3 int", 32'(int_out_n), 32'h0);
        irq_ack[3] = 1'b1;
        @(negedge clk); irq_ack[3] = 1'b0;
        check("irq3 acked", 32'(irq_pending), 32'h0);
        tick(2);
        check("irq3 level no reset", 32'(irq_pending), 32'h0);
        check("irq3 int released", 32'(int_out_n), 32'h1);
        irq_src[3] = 1'b0;
        tick(1);
        irq_src[3] = 1'b1;
        irq_mask = 4'h7;
        tick(3);
        check("masked pending", 32'(irq_pending), 32'b1000);
        check("masked int", 32'(int_out_n), 32'h1);
        irq_mask = 4'hF;

        // Edge and ack collide
        irq_src[2] = 1'b1; irq_ack[2] = 1'b1;
        @(negedge clk); irq_ack[2] = 1'b0;
        check("collision set wins", 32'(irq_pending[2]), 32'h1);

        // Reset mid-frame with pending set
        send(1'b1, 8'(TGT_HID));
        send(1'b0, 8'h05);
        reset = 1'b1;
        @(negedge clk);
        check("midreset pending", 32'(irq_pending), 32'h0);
        check("midreset int", 32'(int_out_n), 32'h1);
        check("midreset dout", 32'(mcu_dout), 32'h00);
        check("midreset din", 32'(tgt_din), 32'h00);
        check("midreset err", 32'(frame_err), 32'h0);
        irq_src = '0;
        tick(1);
        reset = 1'b0;
        tick(1);
        send(1'b0, 8'h55);
        check("post reset no forward", 32'(tgt_strobe), 32'h0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
